array_port_arbiter: RTL and testbench

- Shares one single-port array RAM (the kernel's `a` array: DEPTH words, signed) between two requesters: the host loader/checker and the synthesized kernel datapath.
- Grants at most one access per cycle.
- Routes read data back to the requester that issued the read.
- Provides a lock handshake so the host can take exclusive ownership of the array for bulk load/readback.
- Sits between the top-level control/test logic and the kernel's memory interface, replacing the ad-hoc `controlArr` mux.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rd_tag_pipe.sv | 23 ++
 rtl/array_port_arbiter.sv | 90 +++++++++
 tb/tb_array_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared owner/lock enums and the read tag type for array_port_arbiter
package arb_pkg;
  typedef enum logic {OWN_HOST, OWN_KERN} owner_e;
  typedef enum logic [1:0] {UNLOCKED, DRAINING, LOCKED} lock_state_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   oor;
  } rd_tag_t;
  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_HOST, oor: 1'b0};
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep read tag shift register with a kernel-tag-in-flight flag
module rd_tag_pipe import arb_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t pop,
  output logic    kern_busy
);
  rd_tag_t tags_q [RD_LAT];
  rd_tag_t tags_d [RD_LAT];
  always_comb begin
    tags_d[0] = push;
    for (int i = 1; i < RD_LAT; i++) tags_d[i] = tags_q[i-1];
    kern_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) kern_busy = kern_busy | (tags_q[i].valid && tags_q[i].owner == OWN_KERN);
  end
  assign pop = tags_q[RD_LAT-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < RD_LAT; i++) tags_q[i] <= TAG_IDLE;
    else tags_q <= tags_d;
endmodule

// File: rtl/array_port_arbiter.sv
// array_port_arbiter: round-robin host/kernel arbiter for one single-port RAM with host lock handshake; define ARB_STATS_EN for grant/conflict counters
module array_port_arbiter import arb_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 27,
  parameter int DEPTH  = 1000,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              kern_req,
  input  logic              kern_we,
  input  logic [ADDR_W-1:0] kern_addr,
  input  logic [DATA_W-1:0] kern_wdata,
  output logic              kern_gnt,
  output logic              kern_rvalid,
  output logic [DATA_W-1:0] kern_rdata,
  input  logic              host_lock,
  output logic              lock_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_host_gnt,
  output logic [31:0]       stat_kern_gnt,
  output logic [31:0]       stat_conflict
`endif
);
  lock_state_e state_q;
  owner_e last_q, last_d;
  logic [DATA_W-1:0] host_rdata_q, kern_rdata_q;
  logic kern_ok, sel_we, sel_oor, kern_busy;
  rd_tag_t push, pop;
  always_comb begin
    kern_ok = kern_req && state_q == UNLOCKED && !host_lock;
    host_gnt = host_req && (!kern_ok || last_q == OWN_KERN);
    kern_gnt = kern_ok && !host_gnt;
    mem_addr = host_gnt ? host_addr : kern_gnt ? kern_addr : '0;
    mem_wdata = host_gnt ? host_wdata : kern_gnt ? kern_wdata : '0;
    sel_we = host_gnt ? host_we : kern_gnt && kern_we;
    sel_oor = (host_gnt || kern_gnt) && int'(mem_addr) >= DEPTH;
    mem_we = sel_we && !sel_oor;
    push = '{valid: (host_gnt || kern_gnt) && !sel_we, owner: kern_gnt ? OWN_KERN : OWN_HOST, oor: sel_oor};
    last_d = host_gnt ? OWN_HOST : kern_gnt ? OWN_KERN : last_q;
    host_rvalid = pop.valid && pop.owner == OWN_HOST;
    kern_rvalid = pop.valid && pop.owner == OWN_KERN;
    host_rdata = host_rvalid ? (pop.oor ? '0 : mem_rdata) : host_rdata_q;
    kern_rdata = kern_rvalid ? (pop.oor ? '0 : mem_rdata) : kern_rdata_q;
  end
  assign lock_ack = state_q == LOCKED;
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .kern_busy(kern_busy)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= UNLOCKED;
      last_q <= OWN_KERN;
      host_rdata_q <= '0;
      kern_rdata_q <= '0;
    end else begin
      state_q <= !host_lock ? UNLOCKED : state_q == UNLOCKED ? DRAINING : (state_q == DRAINING && !kern_busy) ? LOCKED : state_q;
      last_q <= last_d;
      host_rdata_q <= host_rdata;
      kern_rdata_q <= kern_rdata;
    end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_host_gnt <= '0;
      stat_kern_gnt <= '0;
      stat_conflict <= '0;
    end else begin
      if (host_gnt && stat_host_gnt != '1) stat_host_gnt <= stat_host_gnt + 32'd1;
      if (kern_gnt && stat_kern_gnt != '1) stat_kern_gnt <= stat_kern_gnt + 32'd1;
      if (host_req && kern_req && stat_conflict != '1) stat_conflict <= stat_conflict + 32'd1;
    end
`endif
endmodule

// File: tb/tb_array_port_arbiter.sv
// tb_array_port_arbiter: directed and randomized checks of array_port_arbiter against a behavioural model
module tb_array_port_arbiter;
  localparam int ADDR_W = 10, DATA_W = 27, DEPTH = 1000, RD_LAT = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic host_req = 1'b0, host_we = 1'b0, kern_req = 1'b0, kern_we = 1'b0, host_lock = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0, kern_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0, kern_wdata = '0;
  logic host_gnt, host_rvalid, kern_gnt, kern_rvalid, lock_ack, mem_we;
  logic [DATA_W-1:0] host_rdata, kern_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [31:0] stat_host_gnt, stat_kern_gnt, stat_conflict;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  array_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .kern_req(kern_req), .kern_we(kern_we), .kern_addr(kern_addr), .kern_wdata(kern_wdata),
    .kern_gnt(kern_gnt), .kern_rvalid(kern_rvalid), .kern_rdata(kern_rdata),
    .host_lock(host_lock), .lock_ack(lock_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_host_gnt(stat_host_gnt), .stat_kern_gnt(stat_kern_gnt), .stat_conflict(stat_conflict)
`endif
  );
  logic [DATA_W-1:0] ram [1<<ADDR_W];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  assign mem_rdata = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  function automatic logic [DATA_W-1:0] init_word(input int i);
    return DATA_W'(27'h15A5A5A ^ (i * 7));
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {int due; bit kern; logic [DATA_W-1:0] data;} resp_t;
  resp_t q[$];
  logic [DATA_W-1:0] m_mem [1<<ADDR_W];
  int m_state = 0;
  bit m_host_last = 1'b0;
  logic [DATA_W-1:0] m_hr = '0, m_kr = '0;
  int cyc = 0;
  always @(negedge clk) begin : model
    bit ko, eh, ek, we, oor, hv, kv, kbusy;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    resp_t r;
    hv = 1'b0; kv = 1'b0; eh = 1'b0; ek = 1'b0; we = 1'b0; oor = 1'b0; kbusy = 1'b0;
    a = '0; wd = '0;
    if (!rst_n) begin
      q.delete();
      m_state = 0; m_host_last = 1'b0; m_hr = '0; m_kr = '0;
    end else begin
      ko = kern_req && m_state == 0 && !host_lock;
      eh = host_req && (!ko || !m_host_last);
      ek = ko && !eh;
      a = eh ? host_addr : ek ? kern_addr : '0;
      wd = eh ? host_wdata : ek ? kern_wdata : '0;
      we = eh ? host_we : ek && kern_we;
      oor = (eh || ek) && int'(a) >= DEPTH;
      foreach (q[i]) if (q[i].kern) kbusy = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].kern) begin kv = 1'b1; m_kr = q[0].data; end
        else begin hv = 1'b1; m_hr = q[0].data; end
        void'(q.pop_front());
      end
    end
    chk("host_gnt", host_gnt, eh);
    chk("kern_gnt", kern_gnt, ek);
    chk("mem_we", mem_we, we && !oor);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, wd);
    chk("host_rvalid", host_rvalid, hv);
    chk("kern_rvalid", kern_rvalid, kv);
    chk("host_rdata", host_rdata, m_hr);
    chk("kern_rdata", kern_rdata, m_kr);
    chk("lock_ack", lock_ack, m_state == 2);
    if (rst_n) begin
      if ((eh || ek) && !we) begin
        r.due = cyc + RD_LAT; r.kern = ek; r.data = oor ? DATA_W'(0) : m_mem[a];
        q.push_back(r);
      end
      if ((eh || ek) && we && !oor) m_mem[a] = wd;
      if (eh || ek) m_host_last = eh;
      if (!host_lock) m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (m_state == 1 && !kbusy) m_state = 2;
    end
    cyc++;
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    host_req = 1'b0; kern_req = 1'b0; host_we = 1'b0; kern_we = 1'b0;
  endtask
  task automatic hreq(input logic we, input int a, input int d);
    host_req = 1'b1; host_we = we; host_addr = ADDR_W'(a); host_wdata = DATA_W'(d);
  endtask
  task automatic kreq(input logic we, input int a, input int d);
    kern_req = 1'b1; kern_we = we; kern_addr = ADDR_W'(a); kern_wdata = DATA_W'(d);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; idle(); host_lock = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
  endtask
  function automatic int rnd_addr();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 1023)) : int'($urandom_range(0, DEPTH - 1));
  endfunction
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = init_word(i);
      m_mem[i] = init_word(i);
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    repeat (2) nxt();
    @(negedge clk);
    chk("rst_lock_ack", lock_ack, 0);
    chk("rst_host_rdata", host_rdata, 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      hreq(1'b1, i, i * 3);
      nxt();
    end
    hreq(1'b0, 5, 0);
    @(negedge clk); chk("rd5_gnt", host_gnt, 1);
    nxt(); idle();
    @(negedge clk); chk("rd5_rvalid", host_rvalid, 1); chk("rd5_rdata", host_rdata, 15);
    nxt();
    @(negedge clk); chk("rd5_pulse", host_rvalid, 0); chk("rd5_hold", host_rdata, 15);
    nxt();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      hreq(1'b0, 10 + i, 0); kreq(1'b0, 100 + i, 0);
      @(negedge clk);
      chk("cont_host_gnt", host_gnt, (i % 2) == 0);
      chk("cont_kern_gnt", kern_gnt, (i % 2) == 1);
      nxt();
    end
    idle();
    @(negedge clk);
    chk("cont_kern_rdata", kern_rdata, 327);
    chk("cont_host_hold", host_rdata, 54);
`ifdef ARB_STATS_EN
    chk("stat_host_gnt", stat_host_gnt, 5);
    chk("stat_kern_gnt", stat_kern_gnt, 5);
    chk("stat_conflict", stat_conflict, 10);
`endif
    nxt();
    kreq(1'b0, 200, 0);
    @(negedge clk); chk("drain_kgnt_t", kern_gnt, 1);
    nxt(); host_lock = 1'b1;
    @(negedge clk);
    chk("drain_krvalid", kern_rvalid, 1); chk("drain_krdata", kern_rdata, 600);
    chk("drain_kgnt_blk", kern_gnt, 0); chk("drain_ack_t1", lock_ack, 0);
    nxt();
    @(negedge clk); chk("drain_ack_t2", lock_ack, 0);
    nxt();
    @(negedge clk); chk("drain_ack_t3", lock_ack, 1);
    repeat (5) nxt();
    host_lock = 1'b0;
    @(negedge clk); chk("unlock_ack_hold", lock_ack, 1); chk("unlock_kgnt_same", kern_gnt, 0);
    nxt();
    @(negedge clk); chk("unlock_ack_drop", lock_ack, 0); chk("unlock_kgnt_resume", kern_gnt, 1);
    nxt(); idle();
    hreq(1'b1, 1000, 'h123);
    @(negedge clk); chk("oor_wr_gnt", host_gnt, 1); chk("oor_wr_mem_we", mem_we, 0);
    nxt(); hreq(1'b0, 1000, 0);
    @(negedge clk); chk("oor_rd_gnt", host_gnt, 1);
    nxt(); idle();
    @(negedge clk); chk("oor_rvalid", host_rvalid, 1); chk("oor_rdata", host_rdata, 0);
    nxt();
    host_lock = 1'b1;
    repeat (4) nxt();
    @(negedge clk); chk("pre_rst_ack", lock_ack, 1);
    nxt(); hreq(1'b0, 7, 0);
    @(negedge clk); chk("mid_gnt", host_gnt, 1);
    nxt(); idle(); host_lock = 1'b0; rst_n = 1'b0;
    @(negedge clk); chk("mid_rvalid", host_rvalid, 0); chk("mid_ack", lock_ack, 0);
    nxt(); rst_n = 1'b1; hreq(1'b0, 8, 0); kreq(1'b0, 9, 0);
    @(negedge clk); chk("post_rst_tie_h", host_gnt, 1); chk("post_rst_tie_k", kern_gnt, 0);
    nxt(); idle();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0; idle(); host_lock = 1'b0;
      end else begin
        rst_n = 1'b1;
        host_req = $urandom_range(0, 3) != 0;
        host_we = $urandom_range(0, 1) == 1;
        host_addr = ADDR_W'(rnd_addr());
        host_wdata = DATA_W'($urandom);
        kern_req = $urandom_range(0, 3) != 0;
        kern_we = $urandom_range(0, 2) == 0;
        kern_addr = ADDR_W'(rnd_addr());
        kern_wdata = DATA_W'($urandom);
        if ($urandom_range(0, 24) == 0) host_lock = ~host_lock;
      end
      nxt();
    end
    rst_n = 1'b1; idle(); host_lock = 1'b0;
    repeat (3) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
